aes_inv_round_ctrl: RTL

Iterative AES-256 decryption round sequencer. It holds the 128-bit cipher state and steps it through the 14 inverse rounds, one round per clock. Each round uses an external combinational InvShiftRows/InvSubBytes stage, an internal AddRoundKey, and an external InvMixColumns stage. It sits between the ciphertext source and the plaintext sink, and reads round keys from the expanded-key bank by index.

---
 rtl/aes_inv_round_ctrl.sv | 89 ++++++++
 1 files changed

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-256 inverse-cipher round sequencer: one inverse round per clock, 14 rounds.
// Optional AES_INV_CTRL_ZEROIZE_EN clears the state register on the DONE->IDLE handshake.
module aes_inv_round_ctrl (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         key_ready_i,
  input  logic         ct_valid_i,
  output logic         ct_ready_o,
  input  logic [127:0] ct_i,
  output logic [3:0]   key_idx_o,
  input  logic [127:0] key_i,
  output logic [127:0] isb_o,
  input  logic [127:0] isb_i,
  output logic [127:0] imc_o,
  input  logic [127:0] imc_i,
  output logic         pt_valid_o,
  input  logic         pt_ready_i,
  output logic [127:0] pt_o,
  output logic         busy_o
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_e;

  fsm_e         r_fsm, w_fsm_nxt;
  logic [127:0] r_st, w_st_nxt;
  logic [3:0]   r_rnd, w_rnd_nxt;
  logic [127:0] w_ark;

  assign w_ark  = isb_i ^ key_i;
  assign imc_o  = w_ark;
  assign isb_o  = r_st;
  assign pt_o   = r_st;
  assign busy_o = (r_fsm != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fsm <= IDLE;
      r_st  <= '0;
      r_rnd <= '0;
    end else begin
      r_fsm <= w_fsm_nxt;
      r_st  <= w_st_nxt;
      r_rnd <= w_rnd_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt  = r_fsm;
    w_st_nxt   = r_st;
    w_rnd_nxt  = r_rnd;
    key_idx_o  = 4'd14;
    ct_ready_o = 1'b0;
    pt_valid_o = 1'b0;
    case (r_fsm)
      IDLE: begin
        ct_ready_o = key_ready_i;
        if (ct_valid_i && key_ready_i) begin
          w_st_nxt  = ct_i ^ key_i;
          w_rnd_nxt = 4'd13;
          w_fsm_nxt = ROUND;
        end
      end
      ROUND: begin
        key_idx_o = r_rnd;
        w_st_nxt  = imc_i;
        w_rnd_nxt = r_rnd - 4'd1;
        if (r_rnd == 4'd1) w_fsm_nxt = FINAL;
      end
      FINAL: begin
        // Last round skips InvMixColumns.
        key_idx_o = 4'd0;
        w_st_nxt  = w_ark;
        w_fsm_nxt = DONE;
      end
      DONE: begin
        key_idx_o  = 4'd0;
        pt_valid_o = 1'b1;
        if (pt_ready_i) begin
          w_fsm_nxt = IDLE;
`ifdef AES_INV_CTRL_ZEROIZE_EN
          w_st_nxt  = '0;
`else
          w_st_nxt  = r_st;
`endif
        end
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end
endmodule
